pe_chain_ctrl: RTL and testbench



---
 rtl/pe_chain_pkg.sv | 17 +
 rtl/pe_chain_ofifo.sv | 58 +++++
 rtl/pe_chain_ctrl.sv | 156 +++++++++++++++
 tb/tb_pe_chain_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_chain_pkg.sv
// Shared types and defaults for the PE chain host controller.
// Holds the controller state encoding and the weight/bias address map.
package pe_chain_pkg;

    localparam int DW_DEF    = 32;
    localparam int LAT_DEF   = 5;
    localparam int DEPTH_DEF = 8;

    localparam logic [2:0] WADDR_BIAS = 3'd5;

    typedef enum logic [1:0] {
        ST_LOAD  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/pe_chain_ofifo.sv
// Result FIFO: a pushed word is visible at the head on the next cycle.
// A push at full is dropped unless a pop lands in the same cycle; a pop at empty is ignored.
module pe_chain_ofifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DW-1:0]            push_dat,
    input  logic                     pop,
    output logic [DW-1:0]            pop_dat,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   cnt_q, cnt_d;
    logic [DW-1:0] mem_q [DEPTH];
    logic          do_push, do_pop;

    assign empty   = (cnt_q == '0);
    assign full    = (cnt_q == (AW+1)'(DEPTH));
    assign count   = cnt_q;
    assign pop_dat = mem_q[rd_ptr_q];

    always_comb begin
        do_pop   = pop && !empty;
        do_push  = push && (!full || do_pop);
        wr_ptr_d = wr_ptr_q + AW'(do_push);
        rd_ptr_d = rd_ptr_q + AW'(do_pop);
        cnt_d    = cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_dat;
        end
    end

endmodule

// File: rtl/pe_chain_ctrl.sv
// Host controller for the 5-tap systolic PE chain: weight load, sample issue, result capture.
// Result appears LAT+1 cycles after issue; sample issue is credit-gated so the chain never overruns the FIFO.
module pe_chain_ctrl
    import pe_chain_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int LAT   = LAT_DEF,
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic          iCLK,
    input  logic          iRSTn,
    input  logic          iXvalid,
    input  logic [DW-1:0] iX,
    output logic          oXready,
    input  logic          iWvalid,
    input  logic [2:0]    iWaddr,
    input  logic [DW-1:0] iWdata,
    output logic          oWerr,
    input  logic          iStart,
    input  logic          iFlush,
    output logic          oBusy,
    output logic [DW-1:0] oChainX,
    output logic [DW-1:0] oW1,
    output logic [DW-1:0] oW2,
    output logic [DW-1:0] oW3,
    output logic [DW-1:0] oW4,
    output logic [DW-1:0] oW5,
    output logic [DW-1:0] oChainPsum,
    input  logic [DW-1:0] iChainPsum,
    output logic          oYvalid,
    output logic [DW-1:0] oY,
    input  logic          iYready
);

    localparam int CW   = $clog2(DEPTH) + 1;
    localparam int NREG = int'(WADDR_BIAS) + 1;

    state_t        state_q, state_d;
    logic [DW-1:0] x_q, x_d;
    logic [LAT:0]  tag_q, tag_d;
    logic [DW-1:0] w_q [NREG];
    logic [DW-1:0] w_d [NREG];
    logic          werr_q, werr_d;

    logic [CW-1:0] inflight;
    logic [CW-1:0] fifo_count;
    logic [CW:0]   credit_used;
    logic          fifo_full, fifo_empty, fifo_pop;
    logic          x_rdy, x_acc;

    // Bit 0 rides with the sample register, bit k with PE k's output; bit LAT marks the cycle
    // whose iChainPsum belongs to a real sample. It stays counted until the FIFO count absorbs it.
    always_comb begin
        inflight = '0;
        for (int i = 0; i <= LAT; i++) begin
            inflight = inflight + CW'(tag_q[i]);
        end
        credit_used = {1'b0, fifo_count} + {1'b0, inflight};
    end

    always_comb begin
        state_d = state_q;
        x_d     = '0;
        tag_d   = {tag_q[LAT-1:0], 1'b0};
        w_d     = w_q;
        werr_d  = 1'b0;
        x_rdy   = 1'b0;
        x_acc   = 1'b0;
        unique case (state_q)
            ST_LOAD: begin
                if (iWvalid) begin
                    if (iWaddr > WADDR_BIAS) begin
                        werr_d = 1'b1;
                    end
                    for (int i = 0; i < NREG; i++) begin
                        if (iWaddr == 3'(i)) begin
                            w_d[i] = iWdata;
                        end
                    end
                end
                if (iStart) begin
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                x_rdy  = !fifo_full && (credit_used < (CW+1)'(DEPTH));
                x_acc  = iXvalid && x_rdy;
                werr_d = iWvalid;
                if (x_acc) begin
                    x_d      = iX;
                    tag_d[0] = 1'b1;
                end
                if (iFlush) begin
                    state_d = ST_FLUSH;
                end
            end
            ST_FLUSH: begin
                werr_d = iWvalid;
                if (inflight == '0) begin
                    state_d = ST_LOAD;
                end
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    always_ff @(posedge iCLK or negedge iRSTn) begin
        if (!iRSTn) begin
            state_q <= ST_LOAD;
            x_q     <= '0;
            tag_q   <= '0;
            werr_q  <= 1'b0;
            for (int i = 0; i < NREG; i++) begin
                w_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            tag_q   <= tag_d;
            werr_q  <= werr_d;
            w_q     <= w_d;
        end
    end

    assign fifo_pop = iYready && !fifo_empty;

    pe_chain_ofifo #(
        .DW    (DW),
        .DEPTH (DEPTH)
    ) u_ofifo (
        .clk      (iCLK),
        .rst_n    (iRSTn),
        .push     (tag_q[LAT]),
        .push_dat (iChainPsum),
        .pop      (fifo_pop),
        .pop_dat  (oY),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    assign oXready    = x_rdy;
    assign oWerr      = werr_q;
    assign oBusy      = (state_q != ST_LOAD);
    assign oChainX    = x_q;
    assign oW1        = w_q[0];
    assign oW2        = w_q[1];
    assign oW3        = w_q[2];
    assign oW4        = w_q[3];
    assign oW5        = w_q[4];
    assign oChainPsum = w_q[WADDR_BIAS];
    assign oYvalid    = !fifo_empty;

endmodule

// File: tb/tb_pe_chain_ctrl.sv
// Directed bench for pe_chain_ctrl with a behavioural 5-stage PE chain closing the loop.
module tb_pe_chain_ctrl;

    logic        iCLK = 1'b0;
    logic        iRSTn = 1'b0;
    logic        iXvalid = 1'b0;
    logic [31:0] iX = '0;
    logic        oXready;
    logic        iWvalid = 1'b0;
    logic [2:0]  iWaddr = '0;
    logic [31:0] iWdata = '0;
    logic        oWerr;
    logic        iStart = 1'b0;
    logic        iFlush = 1'b0;
    logic        oBusy;
    logic [31:0] oChainX, oW1, oW2, oW3, oW4, oW5, oChainPsum, iChainPsum, oY;
    logic        oYvalid;
    logic        iYready = 1'b0;

    int total = 0;
    int bad   = 0;

    pe_chain_ctrl #(.DW(32), .LAT(5), .DEPTH(8)) dut (
        .iCLK(iCLK), .iRSTn(iRSTn),
        .iXvalid(iXvalid), .iX(iX), .oXready(oXready),
        .iWvalid(iWvalid), .iWaddr(iWaddr), .iWdata(iWdata), .oWerr(oWerr),
        .iStart(iStart), .iFlush(iFlush), .oBusy(oBusy),
        .oChainX(oChainX), .oW1(oW1), .oW2(oW2), .oW3(oW3), .oW4(oW4), .oW5(oW5),
        .oChainPsum(oChainPsum), .iChainPsum(iChainPsum),
        .oYvalid(oYvalid), .oY(oY), .iYready(iYready)
    );

    always #5 iCLK = ~iCLK;

    // Free-running chain: PE k adds wk times the broadcast sample and registers the sum.
    logic [31:0] p1, p2, p3, p4, p5;
    always @(posedge iCLK) begin
        p1 <= oChainPsum + oW1 * oChainX;
        p2 <= p1 + oW2 * oChainX;
        p3 <= p2 + oW3 * oChainX;
        p4 <= p3 + oW4 * oChainX;
        p5 <= p4 + oW5 * oChainX;
    end
    assign iChainPsum = p5;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(negedge iCLK);
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        iWvalid = 1'b1;
        iWaddr  = a;
        iWdata  = d;
        tick();
        iWvalid = 1'b0;
    endtask

    task automatic start();
        iStart = 1'b1;
        tick();
        iStart = 1'b0;
    endtask

    task automatic flush();
        iFlush = 1'b1;
        tick();
        iFlush = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (oBusy && n < 60) begin
            tick();
            n++;
        end
        chk(tag, oBusy, 0);
    endtask

    task automatic pop_exp(input string tag, input logic [31:0] e);
        int n = 0;
        while (!oYvalid && n < 60) begin
            tick();
            n++;
        end
        chk({tag, "_vld"}, oYvalid, 1);
        chk(tag, oY, e);
        iYready = 1'b1;
        tick();
        iYready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        int first_y;
        int acc;
        logic seen;

        // Reset values
        tick();
        tick();
        chk("rst_xrdy", oXready, 0);
        chk("rst_yvld", oYvalid, 0);
        chk("rst_werr", oWerr, 0);
        chk("rst_busy", oBusy, 0);
        chk("rst_w1", oW1, 0);
        chk("rst_bias", oChainPsum, 0);
        chk("rst_x", oChainX, 0);
        iRSTn = 1'b1;
        tick();

        // Ramp weights, 5-sample stream
        wr(3'd0, 1); wr(3'd1, 2); wr(3'd2, 3); wr(3'd3, 4); wr(3'd4, 5); wr(3'd5, 0);
        chk("load_w3", oW3, 3);
        chk("load_w5", oW5, 5);
        start();
        chk("run_busy", oBusy, 1);
        chk("run_xrdy", oXready, 1);
        for (int x = 1; x <= 5; x++) begin
            iXvalid = 1'b1;
            iX = 32'(x);
            tick();
        end
        iXvalid = 1'b0;
        flush();
        chk("flush_xrdy", oXready, 0);
        chk("flush_x", oChainX, 0);
        wait_idle("t1_idle");
        pop_exp("t1_y0", 55);
        pop_exp("t1_y1", 40);
        pop_exp("t1_y2", 26);
        pop_exp("t1_y3", 14);
        pop_exp("t1_y4", 5);
        chk("t1_empty", oYvalid, 0);

        // Bias 100, single sample; time the result and the return to LOAD
        wr(3'd5, 100);
        start();
        iXvalid = 1'b1;
        iX = 2;
        tick();
        iXvalid = 1'b0;
        flush();
        n = 0;
        first_y = -1;
        while (oBusy && n < 60) begin
            tick();
            n++;
            if (oYvalid && first_y < 0) first_y = n;
        end
        chk("t2_first_y", first_y, 5);
        chk("t2_idle_cycles", n, 6);
        pop_exp("t2_y", 102);
        chk("t2_single", oYvalid, 0);

        // Rejected writes
        wr(3'd6, 99);
        chk("load_werr", oWerr, 1);
        tick();
        chk("load_werr_pulse", oWerr, 0);
        chk("load_w1_kept", oW1, 1);
        chk("load_bias_kept", oChainPsum, 100);
        start();
        wr(3'd0, 7);
        chk("run_werr", oWerr, 1);
        tick();
        chk("run_werr_pulse", oWerr, 0);
        chk("run_w1_kept", oW1, 1);
        flush();
        wait_idle("t4_idle");

        // Backpressure: consumer stalled, continuous input
        start();
        iXvalid = 1'b1;
        iX = 1;
        acc = 0;
        for (int i = 0; i < 30; i++) begin
            if (oXready) acc++;
            tick();
        end
        chk("bp_acc", acc, 8);
        chk("bp_xrdy", oXready, 0);
        chk("bp_yvld", oYvalid, 1);
        chk("bp_head", oY, 115);
        iYready = 1'b1;
        if (oXready) acc++;
        tick();
        iYready = 1'b0;
        for (int i = 0; i < 15; i++) begin
            if (oXready) acc++;
            tick();
        end
        chk("bp_acc_after_pop", acc, 9);
        chk("bp_xrdy_hold", oXready, 0);
        iXvalid = 1'b0;
        flush();
        wait_idle("t3_idle");
        n = 0;
        iYready = 1'b1;
        while (oYvalid && n < 20) begin
            tick();
            n++;
        end
        iYready = 1'b0;
        chk("bp_drain", n, 8);

        // Gap inside the window
        wr(3'd0, 1); wr(3'd1, 1); wr(3'd2, 1); wr(3'd3, 1); wr(3'd4, 1); wr(3'd5, 0);
        start();
        iXvalid = 1'b1; iX = 1; tick();
        iXvalid = 1'b0;         tick();
        iXvalid = 1'b1; iX = 1; tick();
        iXvalid = 1'b0;
        flush();
        wait_idle("t5_idle");
        pop_exp("gap_y0", 2);
        pop_exp("gap_y1", 1);
        chk("gap_empty", oYvalid, 0);

        // Reset with 3 samples in flight and 2 words queued
        start();
        iXvalid = 1'b1;
        iX = 3;
        for (int i = 0; i < 5; i++) tick();
        iXvalid = 1'b0;
        tick(); tick(); tick();
        chk("pre_rst_yvld", oYvalid, 1);
        chk("pre_rst_busy", oBusy, 1);
        iRSTn = 1'b0;
        #1;
        chk("rst2_yvld", oYvalid, 0);
        chk("rst2_w1", oW1, 0);
        chk("rst2_busy", oBusy, 0);
        chk("rst2_x", oChainX, 0);
        tick();
        iRSTn = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            if (oYvalid) seen = 1'b1;
        end
        chk("rst2_no_push", seen, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
